// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single reg_file write port between the ALU
// pipeline (req0) and the multi-cycle unit (req1); writes to r0 are discarded.
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int SIZE     = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [SIZE-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [SIZE-1:0] req1_data,
  output logic            req1_ready,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [SIZE-1:0] wr_data,
  output logic [7:0]      drop_cnt,
  output logic            dbg_pri
);

  // Handshake: a request transfers in a cycle where reqN_valid && reqN_ready.
  // ready is combinational from both valids, rst, stall and pri; a requester
  // must hold valid/addr/data stable until it sees ready.

  logic            pri;
  logic            grant0;
  logic            grant1;
  logic            grant;
  logic [AW-1:0]   g_addr;
  logic [SIZE-1:0] g_data;
  logic            g_zero;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !stall) begin
      grant0 = req0_valid && (!req1_valid || (pri == 1'b0));
      grant1 = req1_valid && (!req0_valid || (pri == 1'b1));
    end
    grant  = grant0 || grant1;
    g_addr = grant1 ? req1_addr : req0_addr;
    g_data = grant1 ? req1_data : req0_data;
    g_zero = (g_addr == '0);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign dbg_pri    = pri;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      drop_cnt <= 8'd0;
    end else begin
      wr_en <= grant && !g_zero;
      if (grant) begin
        // Priority passes to the requester that just lost (or was idle).
        pri     <= grant0;
        wr_addr <= g_addr;
        wr_data <= g_data;
        if (g_zero && (drop_cnt != 8'hFF))
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural reg_file on the
// write port; inputs change 1ns after posedge, outputs are sampled after that.
module tb_regfile_wb_arbiter;

  localparam int NUM_REGS = 32;
  localparam int SIZE     = 32;
  localparam int AW       = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [SIZE-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [SIZE-1:0] req1_data;
  logic            req1_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [SIZE-1:0] wr_data;
  logic [7:0]      drop_cnt;
  logic            dbg_pri;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [SIZE-1:0] rf [NUM_REGS];

  regfile_wb_arbiter #(.NUM_REGS(NUM_REGS), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .drop_cnt(drop_cnt), .dbg_pri(dbg_pri)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural reg_file with r0 hardwired to zero
  initial for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
  always @(posedge clk) if (wr_en && (wr_addr != '0)) rf[wr_addr] <= wr_data;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h55;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); else pass_cnt++;
      next_cycle();
      chk_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else pass_cnt++;
      chk_cnt++; if (wr_addr !== 5'd0) $display("FAIL reset_wr_addr got %0d want 0", wr_addr); else pass_cnt++;
      chk_cnt++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got %h want 0", wr_data); else pass_cnt++;
      chk_cnt++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else pass_cnt++;
    end
    rst = 1'b0; idle();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h77;
    #1;
    chk_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); else pass_cnt++;
    next_cycle();
    req0_valid = 1'b0;
    chk_cnt++; if (wr_en !== 1'b1) $display("FAIL single_wr_en got %b want 1", wr_en); else pass_cnt++;
    chk_cnt++; if (wr_addr !== 5'd3) $display("FAIL single_wr_addr got %0d want 3", wr_addr); else pass_cnt++;
    chk_cnt++; if (wr_data !== 32'h77) $display("FAIL single_wr_data got %h want 77", wr_data); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (wr_en !== 1'b0) $display("FAIL single_wr_en_clear got %b want 0", wr_en); else pass_cnt++;
    chk_cnt++; if (rf[3] !== 32'h77) $display("FAIL single_rf3 got %h want 77", rf[3]); else pass_cnt++;
    chk_cnt++; if (dbg_pri !== 1'b1) $display("FAIL single_pri got %b want 1", dbg_pri); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy;
    logic [AW-1:0] exp_addr;
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hFF;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hEE;
    for (int i = 0; i < 4; i++) begin
      exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 0) ? 5'd1 : 5'd6;
      #1;
      chk_cnt++; if ({req0_ready, req1_ready} !== exp_rdy) $display("FAIL contend_ready[%0d] got %b want %b", i, {req0_ready, req1_ready}, exp_rdy); else pass_cnt++;
      next_cycle();
      chk_cnt++; if ({wr_en, wr_addr} !== {1'b1, exp_addr}) $display("FAIL contend_wr[%0d] got en=%b addr=%0d want en=1 addr=%0d", i, wr_en, wr_addr, exp_addr); else pass_cnt++;
      chk_cnt++; if (wr_data !== ((i % 2 == 0) ? 32'hFF : 32'hEE)) $display("FAIL contend_data[%0d] got %h", i, wr_data); else pass_cnt++;
    end
    idle();
    next_cycle();
    chk_cnt++; if (rf[1] !== 32'hFF || rf[6] !== 32'hEE) $display("FAIL contend_rf got r1=%h r6=%h want ff ee", rf[1], rf[6]); else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    do_reset();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFF;
    #1;
    chk_cnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL zero_ready got %b want 01", {req0_ready, req1_ready}); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (wr_en !== 1'b0) $display("FAIL zero_wr_en got %b want 0", wr_en); else pass_cnt++;
    chk_cnt++; if (drop_cnt !== 8'd1) $display("FAIL zero_drop1 got %0d want 1", drop_cnt); else pass_cnt++;
    chk_cnt++; if (rf[0] !== 32'h0) $display("FAIL zero_rf0 got %h want 0", rf[0]); else pass_cnt++;
    for (int i = 1; i < 300; i++) next_cycle();
    chk_cnt++; if (drop_cnt !== 8'd255) $display("FAIL zero_drop_sat got %0d want 255", drop_cnt); else pass_cnt++;
    chk_cnt++; if (wr_en !== 1'b0) $display("FAIL zero_wr_en_sat got %b want 0", wr_en); else pass_cnt++;
    idle();
  endtask

  task automatic test_stall();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h22;
    next_cycle();
    // r2 write accepted in the cycle before stall rises; pri is now 1
    stall = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hFF;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hEE;
    #1;
    chk_cnt++; if ({wr_en, wr_addr} !== {1'b1, 5'd2}) $display("FAIL stall_prev_write got en=%b addr=%0d want en=1 addr=2", wr_en, wr_addr); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      chk_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL stall_ready[%0d] got %b want 00", c, {req0_ready, req1_ready}); else pass_cnt++;
      next_cycle();
      if (c == 2) stall = 1'b0;
      #1;
      chk_cnt++; if (wr_en !== 1'b0) $display("FAIL stall_wr_en[%0d] got %b want 0", c, wr_en); else pass_cnt++;
    end
    chk_cnt++; if (dbg_pri !== 1'b1) $display("FAIL stall_pri got %b want 1", dbg_pri); else pass_cnt++;
    chk_cnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL stall_release_ready got %b want 01", {req0_ready, req1_ready}); else pass_cnt++;
    next_cycle();
    chk_cnt++; if ({wr_en, wr_addr} !== {1'b1, 5'd6}) $display("FAIL stall_release_wr got en=%b addr=%0d want en=1 addr=6", wr_en, wr_addr); else pass_cnt++;
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    repeat (3) next_cycle();
    // grants 0,1,0 so far; the last one (addr 1) is on the port now
    rst = 1'b1;
    #1;
    chk_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mid_rst_ready got %b want 00", {req0_ready, req1_ready}); else pass_cnt++;
    chk_cnt++; if ({wr_en, wr_addr} !== {1'b1, 5'd1}) $display("FAIL mid_rst_inflight got en=%b addr=%0d want en=1 addr=1", wr_en, wr_addr); else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    #1;
    chk_cnt++; if (wr_en !== 1'b0) $display("FAIL mid_rst_wr_en got %b want 0", wr_en); else pass_cnt++;
    chk_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mid_rst_first_grant got %b want 10", {req0_ready, req1_ready}); else pass_cnt++;
    next_cycle();
    chk_cnt++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd1, 32'h11}) $display("FAIL mid_rst_after got en=%b addr=%0d data=%h want 1 1 11", wr_en, wr_addr, wr_data); else pass_cnt++;
    idle();
  endtask

  initial begin
    rst = 1'b1; idle();
    req0_addr = '0; req0_data = '0; req1_addr = '0; req1_data = '0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_zero_reg();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the single-write-port `reg_file`. Two writeback sources share the port: requester 0 is the ALU pipeline and requester 1 is the multi-cycle unit (load/mul-div). The block grants at most one write per cycle using round-robin priority, registers the winning write onto `reg_file`'s `wr_en`/`wr_addr`/`wr_data`, and discards writes to register 0 so the MIPS zero register stays hardwired to 0.

## Interface
Parameters:
- NUM_REGS, 32, number of registers in the attached `reg_file`
- SIZE, 32, data width
- AW, `CLOG2(NUM_REGS)`, address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  freeze: no grants while high
- req0_valid  in  1  ALU write request
- req0_addr  in  AW  destination register
- req0_data  in  SIZE  write data
- req0_ready  out  1  request 0 accepted this cycle (valid && ready)
- req1_valid / req1_addr / req1_data / req1_ready  same as requester 0, for the multi-cycle unit
- wr_en  out  1  to `reg_file` `wr_en` (registered)
- wr_addr  out  AW  to `reg_file` `wr_addr` (registered)
- wr_data  out  SIZE  to `reg_file` `wr_data` (registered)
- drop_cnt  out  8  saturating count of accepted writes to address 0

## Operation
- State: priority pointer `pri` (0 or 1), output register {wr_en, wr_addr, wr_data}, drop_cnt.
- Grant is combinational:
  - If rst or stall is high: no grant; both readies are 0.
  - If only one requester has valid high, it is granted.
  - If both have valid high, requester `pri` is granted.
- readyN = grantN. Readies depend on both valids. Requesters must hold valid/addr/data stable until accepted.
- On an accepted request:
  - `pri` becomes the index of the other requester (1 − granted index).
  - With no grant, `pri` holds.
- Output register loads every cycle:
  - wr_en = grant && (granted addr ≠ 0).
  - wr_addr and wr_data = granted addr and data.
  - On a cycle with no grant, wr_en = 0 and wr_addr/wr_data hold their previous values.
- Address 0: the request is accepted (ready = 1, handshake completes, `pri` rotates), but no write is issued. drop_cnt increments and saturates at 255.
- Starvation bound: a requester holding valid high waits at most 1 cycle behind the other (stall cycles excluded).

## Timing
- Reset (rst high at an edge): wr_en = 0, wr_addr = 0, wr_data = 0, pri = 0, drop_cnt = 0. Readies are 0 during any cycle with rst high.
- Reset mid-operation: a request pending in that cycle is not accepted. A registered write from the previous cycle still reaches `reg_file` in the cycle before wr_en clears.
- Latency: a request accepted in cycle t drives wr_en/addr/data during cycle t+1. `reg_file` captures it at the edge ending cycle t+1, and reads show the new value from cycle t+2.
- Throughput: 1 write per cycle sustained; alternating grants under continuous contention.
- Stall asserted in cycle t: no acceptance in t, wr_en = 0 in t+1, `pri` unchanged. A write accepted in t−1 still issues in t.
- Both requesters targeting the same address in consecutive grants: both writes issue in grant order, and the later one wins in `reg_file`.

## Test plan
- **Reset:** rst high for 2 cycles with both valids high → readies 0, wr_en 0, wr_addr 0, wr_data 0, drop_cnt 0.
- **Single requester:** req0 {addr 3, data 32'h77} for 1 cycle → req0_ready = 1; next cycle wr_en = 1, wr_addr = 3, wr_data = 32'h77; read of r3 returns 32'h77 two cycles after acceptance.
- **Contention:** both valid continuously (req0 addr 1, data 32'hFF; req1 addr 6, data 32'hEE) for 4 cycles after reset → grant order 0, 1, 0, 1; wr_addr sequence 1, 6, 1, 6.
- **Zero register:** req1 {addr 0, data 32'hFF} → req1_ready = 1, wr_en stays 0, drop_cnt = 1, r0 still reads 0. Repeat 300 times → drop_cnt = 255.
- **Stall:** both valid, stall high for 3 cycles → readies 0, wr_en 0 from the cycle after stall rises. After stall falls, the requester given by `pri` (unchanged) is granted first.
- **Reset mid-stream:** alternating grants, then rst high for 1 cycle → that cycle's requests are not accepted, and the following cycle has wr_en = 0. After reset, requester 0 wins the first contended grant.
